// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard enables, EX redirect, instruction-memory port, IF/ID outputs.
// Latency: none; this file only groups the wires.
// Backpressure: carried by the pc/if_id enables, which are driven by the hazard unit.
interface fetch_stage_if;
    logic        i_pc_enable;
    logic        i_if_id_enable;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_instr;

    // Fetch stage side.
    modport slave (
        input  i_pc_enable,
        input  i_if_id_enable,
        input  i_redirect_valid,
        input  i_redirect_pc,
        input  i_imem_rdata,
        output o_imem_addr,
        output o_id_valid,
        output o_id_pc,
        output o_id_instr
    );

    // Environment side: hazard unit, EX stage, instruction memory, decode.
    modport master (
        output i_pc_enable,
        output i_if_id_enable,
        output i_redirect_valid,
        output i_redirect_pc,
        output i_imem_rdata,
        input  o_imem_addr,
        input  o_id_valid,
        input  o_id_pc,
        input  o_id_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, sync imem addressing, one-entry stall hold buffer, IF/ID register.
// Latency: 2 cycles from the PC being presented to the instruction appearing in IF/ID; 1 instr/cycle.
// Backpressure: enables low freeze PC/IF/ID; the read data that arrives during a stall is parked.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         i_clk,
    input  logic         i_reset,
    fetch_stage_if.slave bus
);

    logic [31:0] pc_q,        pc_d;
    logic [31:0] f_pc_q,      f_pc_d;
    logic        f_valid_q,   f_valid_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] id_pc_q,     id_pc_d;
    logic [31:0] id_instr_q,  id_instr_d;
    logic        id_valid_q,  id_valid_d;
    logic [31:0] fetch_data;

    // Data for the in-flight fetch: parked copy if a stall captured it, else live memory output.
    assign fetch_data = hold_valid_q ? hold_data_q : bus.i_imem_rdata;

    // Next-state: redirect squashes everything younger, otherwise each register follows its enable.
    always_comb begin
        pc_d         = pc_q;
        f_pc_d       = f_pc_q;
        f_valid_d    = f_valid_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;

        if (bus.i_redirect_valid) begin
            pc_d         = bus.i_redirect_pc;
            f_valid_d    = 1'b0;
            hold_valid_d = 1'b0;
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_INSTR;
            id_pc_d      = 32'h0;
        end else begin
            if (bus.i_pc_enable) begin
                pc_d      = pc_q + 32'd4;
                f_pc_d    = pc_q;
                f_valid_d = 1'b1;
            end
            if (bus.i_if_id_enable) begin
                id_valid_d   = f_valid_q;
                id_pc_d      = f_pc_q;
                id_instr_d   = f_valid_q ? fetch_data : NOP_INSTR;
                hold_valid_d = 1'b0;
            end else if (f_valid_q && !hold_valid_q) begin
                // Memory moves on to pc_q next cycle, so this word must be kept now.
                hold_data_d  = bus.i_imem_rdata;
                hold_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q         <= RESET_PC;
            f_pc_q       <= 32'h0;
            f_valid_q    <= 1'b0;
            hold_data_q  <= 32'h0;
            hold_valid_q <= 1'b0;
            id_pc_q      <= 32'h0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            f_pc_q       <= f_pc_d;
            f_valid_q    <= f_valid_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign bus.o_imem_addr = pc_q;
    assign bus.o_id_valid  = id_valid_q;
    assign bus.o_id_pc     = id_pc_q;
    assign bus.o_id_instr  = id_instr_q;

endmodule
